layer_serializer: RTL and testbench
===================================

// Module: layer_serializer
// PURPOSE
//  Converts a parallel layer result vector (DIM signed elements, one valid strobe) back into
//  the element-per-cycle serial stream that the next fully-connected layer consumes.
//  Sits between a layer's out_dat/out_valid bus and the next layer's in_dat/in_valid port.
//  Re-formats each element from the [1,IN_FRAC] activation format to the [*,OUT_FRAC] input format.
//  One-deep pending buffer absorbs a vector that arrives while the previous one is still streaming.
// PARAMETERS
//  DIM       8   elements per vector
//  IN_W      8   input element width, signed, IN_FRAC fractional bits
//  IN_FRAC   7   fractional bits of input element
//  OUT_W     16  output element width, signed, OUT_FRAC fractional bits
//  OUT_FRAC  7   fractional bits of output element; OUT_FRAC>=IN_FRAC
//  Constraint: OUT_W >= IN_W + (OUT_FRAC-IN_FRAC).
// PORTS
//  clk        in   1              clock, all logic on rising edge
//  rst        in   1              synchronous active-high reset
//  in_dat     in   IN_W x [DIM]   parallel vector; in_dat[0] is streamed first
//  in_valid   in   1              1-cycle strobe, in_dat sampled on this edge
//  out_dat    out  OUT_W          serial element
//  out_valid  out  1              out_dat valid this cycle
//  out_last   out  1              high with element DIM-1 of each vector
//  busy       out  1              active vector streaming or pending buffer full
//  overflow   out  1              sticky: a vector was dropped
// BEHAVIOUR
//  Reset: out_dat=0, out_valid=0, out_last=0, busy=0, overflow=0, counter=0,
//   pending empty, state IDLE. Reset mid-stream aborts the vector; out_valid low the
//   cycle after rst is sampled; pending contents discarded.
//  Conversion: out = sign_extend(elem) <<< (OUT_FRAC-IN_FRAC); exact, no rounding/saturation.
//  Registers: active[DIM] (vector being sent), pend[DIM]+pend_full, idx (0..DIM-1).
//  FSM IDLE: in_valid -> capture into active, idx=0, go SEND.
//   First element on out_dat with out_valid=1 in the cycle after in_valid (latency 1).
//  FSM SEND: each cycle emit active[idx], out_valid=1, idx++. At idx==DIM-1 assert out_last;
//   next cycle: if pend_full (or in_valid this cycle) load it and continue SEND at idx=0 with
//   no bubble; else go IDLE, out_valid=0.
//  in_valid arbitration (priority order, evaluated per cycle):
//   a) IDLE, or SEND with idx==DIM-1 and pend empty -> load active directly.
//   b) SEND with idx==DIM-1 and pend_full -> pend moves to active, new vector into pend.
//   c) SEND, idx<DIM-1, pend empty -> store in pend, pend_full=1.
//   d) SEND, idx<DIM-1, pend_full -> drop new vector, overflow=1 (sticky until rst);
//      streams in progress and pending unaffected.
//  Stream is strictly in order, never interleaved; no downstream backpressure.
//  busy = (state==SEND) | pend_full, registered alongside state.
//  DIM==1: every element has out_last=1; case a/b apply every cycle.
// TESTING
//  1 Single vector in_dat={0x01,0x02,..,0x08} -> out 0x0001..0x0008 on 8 consecutive
//    cycles starting 1 cycle after in_valid; out_last only on 0x0008; then out_valid=0.
//  2 Sign extension: elements 0x80,0x7F,0xFF -> 0xFF80,0x007F,0xFFFF.
//  3 Second vector strobed at idx=3 -> 16 contiguous out_valid cycles, no gap, order kept.
//  4 Vector B strobed exactly on out_last of A (pend empty) -> B element 0 next cycle;
//    overflow stays 0.
//  5 Three strobes on cycles 0,2,4 -> vectors 1 and 2 streamed (16 cycles), third dropped,
//    overflow=1 from cycle 5 onward.
//  6 rst asserted at idx=4 with pend_full -> out_valid=0, busy=0, overflow=0 next cycle;
//    new vector afterwards streams normally from element 0.

Source files
------------

// File: rtl/layer_serializer.sv
// Parallel-to-serial converter between fully-connected layers: streams DIM elements
// one per cycle, re-scaling each from [1,IN_FRAC] to [*,OUT_FRAC] fixed point.
module layer_serializer #(
    parameter int DIM      = 8,
    parameter int IN_W     = 8,
    parameter int IN_FRAC  = 7,
    parameter int OUT_W    = 16,
    parameter int OUT_FRAC = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DIM-1:0][IN_W-1:0]  in_dat,
    input  logic                      in_valid,
    output logic [OUT_W-1:0]          out_dat,
    output logic                      out_valid,
    output logic                      out_last,
    output logic                      busy,
    output logic                      overflow
);

    localparam int IDX_W = (DIM > 1) ? $clog2(DIM) : 1;
    localparam int SHIFT = OUT_FRAC - IN_FRAC;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                    state_q, state_d;
    logic [DIM-1:0][IN_W-1:0]  active_q, pend_q;
    logic                      pend_full_q;
    logic [IDX_W-1:0]          idx_q;
    logic                      overflow_q;

    logic load_in, load_pend, store_pend, clear_pend, drop;
    logic at_last;

    assign at_last = (idx_q == LAST_IDX);

    // Arbitration of an incoming strobe against the stream in progress.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        load_in    = 1'b0;
        load_pend  = 1'b0;
        store_pend = 1'b0;
        clear_pend = 1'b0;
        drop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_in = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (at_last) begin
                    if (pend_full_q) begin
                        load_pend  = 1'b1;
                        store_pend = in_valid;
                        clear_pend = !in_valid;
                    end else if (in_valid) begin
                        load_in = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (in_valid) begin
                    store_pend = !pend_full_q;
                    drop       = pend_full_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pend_full_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_in || load_pend)
                idx_q <= '0;
            else if (state_q == SEND)
                idx_q <= idx_q + IDX_W'(1);
            if (store_pend)
                pend_full_q <= 1'b1;
            else if (clear_pend)
                pend_full_q <= 1'b0;
            if (drop)
                overflow_q <= 1'b1;
        end
    end

    // NOTE: vector storage is not reset; state and pend_full qualify it, so reset only clears flags.
    always_ff @(posedge clk) begin
        if (load_in)
            active_q <= in_dat;
        else if (load_pend)
            active_q <= pend_q;
        if (store_pend)
            pend_q <= in_dat;
    end

    // Exact re-scaling: sign extend, then align the binary point.
    logic [IN_W-1:0]  elem;
    logic [OUT_W-1:0] ext;
    always_comb begin
        elem             = active_q[idx_q];
        ext              = {OUT_W{elem[IN_W-1]}};
        ext[IN_W-1:0]    = elem;
        ext              = ext << SHIFT;
    end

    assign out_valid = (state_q == SEND);
    assign out_last  = out_valid && at_last;
    assign out_dat   = out_valid ? ext : '0;
    assign busy      = out_valid || pend_full_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_layer_serializer.sv
// Scoreboard bench for layer_serializer: expected elements are queued at each strobe
// and matched against the serial stream by a negedge monitor.
module tb_layer_serializer;

    localparam int DIM = 8;

    typedef logic [DIM-1:0][7:0] vec_t;
    typedef struct packed {
        logic [15:0] dat;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    vec_t        in_dat = '0;
    logic        in_valid = 1'b0;
    logic [15:0] out_dat;
    logic        out_valid, out_last, busy, overflow;

    int   checks = 0;
    int   errors = 0;
    int   valid_seen = 0;
    exp_t sb[$];

    layer_serializer #(.DIM(DIM), .IN_W(8), .IN_FRAC(7), .OUT_W(16), .OUT_FRAC(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_dat    (in_dat),
        .in_valid  (in_valid),
        .out_dat   (out_dat),
        .out_valid (out_valid),
        .out_last  (out_last),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Same fractional width on both sides: pure sign extension.
    function automatic logic [15:0] conv(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            exp_t e;
            valid_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL stream_unexpected: got dat=%h last=%b, expected no output", out_dat, out_last);
            end else begin
                e = sb.pop_front();
                if (out_dat !== e.dat || out_last !== e.last) begin
                    errors++;
                    $display("FAIL stream_elem: got dat=%h last=%b, expected dat=%h last=%b",
                             out_dat, out_last, e.dat, e.last);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_vec(input vec_t v);
        for (int i = 0; i < DIM; i++) sb.push_back('{dat: conv(v[i]), last: (i == DIM - 1)});
    endtask

    task automatic drive(input vec_t v, input bit expect_out);
        in_dat   = v;
        in_valid = 1'b1;
        if (expect_out) push_vec(v);
    endtask

    task automatic expect_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic expect_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            tick();
            if (sb.size() == 0 && out_valid !== 1'b1) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending elements, expected 0", name, sb.size());
        end
    endtask

    function automatic vec_t ramp(input logic [7:0] base);
        vec_t v;
        for (int i = 0; i < DIM; i++) v[i] = base + 8'(i);
        return v;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        expect_bit("reset_out_valid", out_valid, 1'b0);
        expect_bit("reset_out_last", out_last, 1'b0);
        expect_bit("reset_busy", busy, 1'b0);
        expect_bit("reset_overflow", overflow, 1'b0);
        expect_bit("reset_out_dat_zero", out_dat == 16'h0, 1'b1);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int start = valid_seen;
        drive(ramp(8'h01), 1'b1);
        tick();
        in_valid = 1'b0;
        expect_bit("single_latency", out_valid, 1'b1);
        expect_bit("single_busy", busy, 1'b1);
        wait_drain("single");
        expect_int("single_count", valid_seen - start, 8);
        expect_bit("single_idle_valid", out_valid, 1'b0);
        expect_bit("single_idle_busy", busy, 1'b0);
    endtask

    task automatic test_sign_ext();
        vec_t v;
        logic [15:0] exp_vals [DIM] = '{16'hFF80, 16'h007F, 16'hFFFF, 16'h0000,
                                        16'h0040, 16'hFFC0, 16'h0001, 16'hFFFE};
        v[0] = 8'h80; v[1] = 8'h7F; v[2] = 8'hFF; v[3] = 8'h00;
        v[4] = 8'h40; v[5] = 8'hC0; v[6] = 8'h01; v[7] = 8'hFE;
        drive(v, 1'b0);
        for (int i = 0; i < DIM; i++) sb.push_back('{dat: exp_vals[i], last: (i == DIM - 1)});
        tick();
        in_valid = 1'b0;
        wait_drain("sign_ext");
    endtask

    task automatic test_back_to_back();
        int start = valid_seen;
        int run = 0;
        drive(ramp(8'h10), 1'b1);
        for (int k = 1; k <= 17; k++) begin
            tick();
            in_valid = 1'b0;
            if (k == 4) drive(ramp(8'h20), 1'b1);
            if (k <= 16 && out_valid === 1'b1) run++;
            if (k == 17) expect_bit("b2b_end_valid", out_valid, 1'b0);
        end
        in_valid = 1'b0;
        expect_int("b2b_contiguous", run, 16);
        wait_drain("b2b");
        expect_int("b2b_count", valid_seen - start, 16);
    endtask

    task automatic test_on_last();
        int start = valid_seen;
        drive(ramp(8'h30), 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick();
            in_valid = 1'b0;
        end
        expect_bit("onlast_last_seen", out_last, 1'b1);
        drive(ramp(8'h40), 1'b1);
        tick();
        in_valid = 1'b0;
        expect_bit("onlast_no_bubble", out_valid, 1'b1);
        wait_drain("onlast");
        expect_int("onlast_count", valid_seen - start, 16);
        expect_bit("onlast_overflow", overflow, 1'b0);
    endtask

    task automatic test_overflow();
        int start = valid_seen;
        drive(ramp(8'h50), 1'b1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            in_valid = 1'b0;
            if (k == 2) drive(ramp(8'h60), 1'b1);
            if (k == 4) begin
                expect_bit("ovf_before_drop", overflow, 1'b0);
                drive(ramp(8'h70), 1'b0);
            end
        end
        expect_bit("ovf_set_cycle5", overflow, 1'b1);
        wait_drain("ovf");
        expect_int("ovf_count", valid_seen - start, 16);
        expect_bit("ovf_sticky", overflow, 1'b1);
    endtask

    task automatic test_reset_mid();
        int start;
        drive(ramp(8'h80), 1'b1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            in_valid = 1'b0;
            if (k == 2) drive(ramp(8'h90), 1'b1);
        end
        expect_bit("rstmid_busy_before", busy, 1'b1);
        rst = 1'b1;
        tick();
        expect_bit("rstmid_valid", out_valid, 1'b0);
        expect_bit("rstmid_busy", busy, 1'b0);
        expect_bit("rstmid_overflow", overflow, 1'b0);
        sb.delete();
        rst = 1'b0;
        tick();
        start = valid_seen;
        drive(ramp(8'hA0), 1'b1);
        tick();
        in_valid = 1'b0;
        wait_drain("rstmid");
        expect_int("rstmid_count", valid_seen - start, 8);
    endtask

    initial begin
        test_reset();
        test_single();
        test_sign_ext();
        test_back_to_back();
        test_on_last();
        test_overflow();
        test_reset_mid();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
